// File: rtl/scoreboard_issue_pkg.sv
// Shared types and sizes for the scoreboard issue slot.
package scoreboard_issue_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/scoreboard_issue_picker.sv
// Fixed-priority picker: grants the lowest-index requester (oldest entry).
module oldest_eligible_picker #(
  parameter int ENTRIES = 4
) (
  input  logic [ENTRIES-1:0] req,
  output logic [ENTRIES-1:0] grant,
  output logic               found
);

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (req[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scoreboard_issue.sv
// Scoreboard issue stage: picks the oldest hazard-free entry into a one-deep
// issue slot and tracks pending destination registers.
//
// state | meaning
// EMPTY | slot holds nothing; any eligible entry may load
// FULL  | slot holds an instruction; reload only on the accept cycle
module scoreboard_issue
  import scoreboard_issue_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int XLEN    = 32
) (
  input  logic                           clock,
  input  logic                           reset_sync,
  input  logic [ENTRIES*XLEN-1:0]        entry_instr,
  input  logic [ENTRIES*XLEN-1:0]        entry_pc,
  input  logic [ENTRIES*REG_IDX_W-1:0]   entry_rs1,
  input  logic [ENTRIES*REG_IDX_W-1:0]   entry_rs2,
  input  logic [ENTRIES*REG_IDX_W-1:0]   entry_rd,
  input  logic [ENTRIES-1:0]             entry_running,
  output logic [ENTRIES-1:0]             start,
  output logic                           issue_valid,
  input  logic                           issue_ready,
  output logic [XLEN-1:0]                issue_instr,
  output logic [XLEN-1:0]                issue_pc,
  output logic [REG_IDX_W-1:0]           issue_rs1,
  output logic [REG_IDX_W-1:0]           issue_rs2,
  output logic [REG_IDX_W-1:0]           issue_rd,
  input  logic                           wb_valid,
  input  logic [REG_IDX_W-1:0]           wb_rd,
  output logic [NUM_REGS-1:0]            busy_regs
);

  slot_state_e state, state_next;

  logic [NUM_REGS-1:0]  busy_prev;
  logic [NUM_REGS-1:0]  busy_next;
  logic [NUM_REGS-1:0]  blocked;
  logic [ENTRIES-1:0]   eligible;
  logic [ENTRIES-1:0]   req;
  logic [ENTRIES-1:0]   grant;
  logic                 found;
  logic                 loadable;

  logic [XLEN-1:0]      sel_instr;
  logic [XLEN-1:0]      sel_pc;
  logic [REG_IDX_W-1:0] sel_rs1;
  logic [REG_IDX_W-1:0] sel_rs2;
  logic [REG_IDX_W-1:0] sel_rd;

  // No writeback bypass: a register stays blocked for one extra cycle after
  // its busy bit clears, so dependents start two cycles after the writeback.
  assign blocked = busy_regs | busy_prev;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      eligible[i] = (entry_instr[i*XLEN +: XLEN] != '0)
                 && !entry_running[i]
                 && !blocked[entry_rs1[i*REG_IDX_W +: REG_IDX_W]]
                 && !blocked[entry_rs2[i*REG_IDX_W +: REG_IDX_W]]
                 && !blocked[entry_rd[i*REG_IDX_W +: REG_IDX_W]];
    end
  end

  assign issue_valid = (state == FULL);
  assign loadable    = (state == EMPTY) || issue_ready;
  assign req         = (loadable && !reset_sync) ? eligible : '0;

  oldest_eligible_picker #(
    .ENTRIES (ENTRIES)
  ) u_picker (
    .req   (req),
    .grant (grant),
    .found (found)
  );

  assign start = grant;

  always_comb begin
    sel_instr = '0;
    sel_pc    = '0;
    sel_rs1   = '0;
    sel_rs2   = '0;
    sel_rd    = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (grant[i]) begin
        sel_instr = sel_instr | entry_instr[i*XLEN +: XLEN];
        sel_pc    = sel_pc    | entry_pc[i*XLEN +: XLEN];
        sel_rs1   = sel_rs1   | entry_rs1[i*REG_IDX_W +: REG_IDX_W];
        sel_rs2   = sel_rs2   | entry_rs2[i*REG_IDX_W +: REG_IDX_W];
        sel_rd    = sel_rd    | entry_rd[i*REG_IDX_W +: REG_IDX_W];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (found) state_next = FULL;
      FULL:    if (issue_ready && !found) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Set is applied after clear so a same-edge collision leaves the bit set.
  always_comb begin
    busy_next = busy_regs;
    if (wb_valid) busy_next[wb_rd] = 1'b0;
    if (found && (sel_rd != '0)) busy_next[sel_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset_sync) begin
      state       <= EMPTY;
      busy_regs   <= '0;
      busy_prev   <= '0;
      issue_instr <= '0;
      issue_pc    <= '0;
      issue_rs1   <= '0;
      issue_rs2   <= '0;
      issue_rd    <= '0;
    end else begin
      state     <= state_next;
      busy_regs <= busy_next;
      busy_prev <= busy_regs;
      if (found) begin
        issue_instr <= sel_instr;
        issue_pc    <= sel_pc;
        issue_rs1   <= sel_rs1;
        issue_rs2   <= sel_rs2;
        issue_rd    <= sel_rd;
      end
    end
  end

endmodule

// File: doc/scoreboard_issue.md
SCOREBOARD_ISSUE -- requirements
Module: scoreboard_issue

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 4, giving the number of scoreboard cells scanned; index 0 is the oldest entry.
REQ-002 The block SHALL have parameter XLEN, default 32, giving the instruction and PC width.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_sync  input  1  synchronous, active-high reset.
REQ-005 entry_instr  input  ENTRIES*XLEN  flattened cell instruction outputs; entry i at bits [i*XLEN +: XLEN].
REQ-006 entry_pc  input  ENTRIES*XLEN  flattened cell PC outputs.
REQ-007 entry_rs1 / entry_rs2 / entry_rd  input  ENTRIES*5 each  flattened cell register indices.
REQ-008 entry_running  input  ENTRIES  per-cell running flag.
REQ-009 start  output  ENTRIES  one-hot, combinational; marks the cell selected this cycle.
REQ-010 issue_valid  output  1  the issue slot holds an instruction.
REQ-011 issue_ready  input  1  the execution unit accepts the slot contents this cycle.
REQ-012 issue_instr / issue_pc  output  XLEN each; issue_rs1 / issue_rs2 / issue_rd  output  5 each  registered issue-slot contents.
REQ-013 wb_valid  input  1; wb_rd  input  5  writeback completion of destination wb_rd.
REQ-014 busy_regs  output  32  registered pending-destination bitmap.

Function
REQ-015 Entry i SHALL be valid when its instruction is nonzero.
REQ-016 Entry i SHALL be eligible when it is valid, entry_running[i]=0, busy_regs[rs1]=0, busy_regs[rs2]=0, and busy_regs[rd]=0 (WAW check).
REQ-017 Register x0 SHALL never be busy; busy_regs[0] SHALL read 0 at all times.
REQ-018 The slot SHALL be loadable when issue_valid=0 or (issue_valid & issue_ready).
REQ-019 When the slot is loadable, the lowest-index eligible entry SHALL be selected; start[i] SHALL be 1 for that entry only, in the same cycle.
REQ-020 start SHALL be all-zero when the slot is not loadable, when no entry is eligible, or when reset_sync=1.
REQ-021 On the edge following a selection, the slot SHALL capture the selected entry's fields, issue_valid SHALL be 1, and busy_regs[rd] SHALL be set if rd != 0. Selection-to-issue_valid latency is one cycle.
REQ-022 Once set, issue_valid and all issue_* outputs SHALL stay stable until the cycle in which issue_ready=1.
REQ-023 On an accept with no new selection, issue_valid SHALL clear on the next edge.
REQ-024 On an accept with a new selection, the slot SHALL reload back-to-back with no bubble.
REQ-025 When wb_valid=1, busy_regs[wb_rd] SHALL clear on the next edge. There is no bypass: a dependent entry becomes eligible one cycle after the clear is visible.
REQ-026 If a set and a clear target the same register on the same edge, the set SHALL win.
REQ-027 issue_ready SHALL be ignored while issue_valid=0.
REQ-028 The slot state machine SHALL have two states: EMPTY and FULL.
 - EMPTY->FULL on selection.
 - FULL->FULL on hold, or on accept with reselection.
 - FULL->EMPTY on accept without reselection.

Reset
REQ-029 When reset_sync=1 at an edge, the state SHALL become EMPTY, and issue_valid, all issue_* outputs and busy_regs SHALL become 0.
REQ-030 A reset during FULL SHALL discard the slot contents; no start pulse and no busy set SHALL occur in the reset cycle.

Structure
REQ-031 The shared package SHALL hold the register-index width (5), the register count (32) and the slot-state enum {EMPTY, FULL}.
REQ-032 The priority selector SHALL be a sub-module named oldest_eligible_picker (ENTRIES-bit request vector in, one-hot grant plus found flag out); the remaining logic SHALL be inline.

Verification
REQ-033 The bench SHALL cover a simple issue: entry0 = {instr 0x00A00093, rd 1}, others empty, issue_ready=1 -> start=0001 in the same cycle, issue_valid=1 and busy_regs[1]=1 one cycle later.
REQ-034 The bench SHALL cover a RAW hazard: entry0 rd=5 issued, entry1 rs1=5 -> entry1 is not started until wb_valid=1 with wb_rd=5, then start=0010 two cycles after the wb cycle.
REQ-035 The bench SHALL cover backpressure: issue_ready=0 for 3 cycles -> issue_* outputs stay constant, start=0; the accept cycle with entry2 eligible gives start=0100 and the slot reloads with no bubble.
REQ-036 The bench SHALL cover priority: entries 1 and 3 both eligible, entry0 running -> start=0010.
REQ-037 The bench SHALL cover set/clear collision: wb_rd=7 in the same cycle as a selection with rd=7 -> busy_regs[7]=1 after the edge.
REQ-038 The bench SHALL cover reset mid-operation: reset_sync pulsed while FULL with busy_regs=0x0000_0022 -> next cycle issue_valid=0, busy_regs=0, start=0 during reset.
